regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port among NREQ writeback sources (ALU, FPU, load unit).
//  Arbitrates round-robin and accepts at most one request per cycle over a valid/ready handshake.
//  Registers the winner onto the regfile write signals (reg, data, regWrite, float).
//  Sits between the writeback stage and registerFile; supports a hold for pipeline freezes.
// PARAMETERS
//  NREQ    3   number of requesters (2..4)
//  ADDR_W  6   register address width, matches registerFile readReg/writeReg
//  DATA_W  32  write data width
//  CNT_W   16  width of committed-write counter
// PORTS
//  clk         in   1             single clock; all state changes on posedge
//  rst_n       in   1             asynchronous, active-low reset
//  req_valid   in   NREQ          request i pending
//  req_ready   out  NREQ          grant; transfer when valid[i]&&ready[i]
//  req_reg     in   NREQ*ADDR_W   packed target register, slice i = [i*ADDR_W +: ADDR_W]
//  req_data    in   NREQ*DATA_W   packed write data, slice i
//  req_float   in   NREQ          1 = float bank, 0 = integer bank
//  hold        in   1             1 = grant nothing this cycle
//  wr_reg      out  ADDR_W        to registerFile writeReg
//  wr_data     out  DATA_W        to registerFile writeData
//  wr_en       out  1             to registerFile regWrite
//  wr_float    out  1             to registerFile float
//  grant_id    out  2             index of the requester that owns the current wr_* beat
//  writes_done out  CNT_W         count of committed writes, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset, async: all outputs 0, state=IDLE, rr_ptr=NREQ-1 so requester 0 wins first.
//   req_ready is forced to 0 while rst_n=0.
//  Reset mid-operation: an accepted but uncommitted beat is dropped and wr_en falls immediately.
//   Requesters keep valid asserted and re-arbitrate after reset.
//  FSM states: IDLE (no write), WRITE (wr_en=1), HOLD (frozen). Evaluated each posedge:
//   hold=1 -> HOLD;
//   else a grant that is not discarded -> WRITE;
//   else -> IDLE.
//  wr_en = (state==WRITE). Any beat already in WRITE completes even if hold rises that cycle.
//  Grant (combinational): if hold=0, scan from (rr_ptr+1) mod NREQ upward with wrap.
//   The first valid requester gets ready=1; at most one ready bit is set.
//   If hold=1 or no requester is valid, ready=0.
//  ready depends on valid. Requesters must not make valid depend on ready.
//   Payload must stay stable while valid=1 and ready=0.
//  Accept at posedge: wr_reg/wr_data/wr_float/grant_id <= winner's slice; rr_ptr <= winner index.
//   Latency: grant in cycle N, wr_en=1 during N+1, regfile commits at the end of N+1.
//   Throughput: one write per cycle; back-to-back grants keep wr_en high.
//  Integer r0 discard: winner with float=0 and reg=0 is accepted (ready=1, rr_ptr advances).
//   It produces no write: next state IDLE, wr_en=0, counter unchanged. Float f0 writes normally.
//  Same target register from two requesters: serialized in grant order; the later grant lands last.
//  writes_done increments by 1 on each cycle with wr_en=1 and wraps 2^CNT_W-1 -> 0.
//  wr_reg/wr_data/wr_float/grant_id keep their last values when wr_en=0.
// TESTING
//  1 Reset: rst_n=0 with all valid=1 -> ready=000, wr_en=0, writes_done=0.
//    Release -> req0 granted first cycle.
//  2 Single: valid=001, reg=1, data=44, float=0 -> ready=001 in cycle N.
//    Cycle N+1: wr_en=1, wr_reg=1, wr_data=44. registerFile reads 44 at r1 afterwards.
//  3 Round-robin: valid=111 held 6 cycles -> grant order 0,1,2,0,1,2.
//    wr_en high 6 consecutive cycles, writes_done=6.
//  4 Hold: valid=010, hold=1 for 3 cycles -> ready=000, wr_en=0, state HOLD.
//    hold=0 -> ready=010, wr_en=1 next cycle.
//  5 r0 discard: req0 int reg=0 data=7 -> accepted, wr_en stays 0, writes_done unchanged.
//    Same with float=1 -> wr_en=1, wr_float=1.
//  6 Mid-op reset: grant req2 (reg=5, data=99), assert rst_n=0 before the commit edge.
//    wr_en drops at once, no write to r5; req2 regranted after reset.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback requesters and the register-file write arbiter:
// per-requester valid/ready/payload plus the registered write beat and commit counter.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_float;
    logic                   hold;
    logic [ADDR_W-1:0]      wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_en;
    logic                   wr_float;
    logic [1:0]             grant_id;
    logic [CNT_W-1:0]       writes_done;

    modport master (
        output req_valid, req_reg, req_data, req_float, hold,
        input  req_ready, wr_reg, wr_data, wr_en, wr_float, grant_id, writes_done
    );

    modport slave (
        input  req_valid, req_reg, req_data, req_float, hold,
        output req_ready, wr_reg, wr_data, wr_en, wr_float, grant_id, writes_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// writeback sources; the winning beat is registered onto the regfile write signals.
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam int         SLOTS = 4;

    // Requester inputs padded to four slots so a 2-bit index always lands in range.
    logic [SLOTS-1:0]  validPad;
    logic [SLOTS-1:0]  floatPad;
    logic [ADDR_W-1:0] regPad  [SLOTS];
    logic [DATA_W-1:0] dataPad [SLOTS];

    logic [1:0]        state;
    logic [1:0]        nextState;
    logic [1:0]        rrPtr;
    logic [1:0]        winner;
    logic [2:0]        scanIdx;
    logic              grantValid;
    logic              discard;

    logic [ADDR_W-1:0] wrReg;
    logic [DATA_W-1:0] wrData;
    logic              wrFloat;
    logic [1:0]        grantId;
    logic [CNT_W-1:0]  writesDone;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NREQ) begin : g_used
                assign validPad[gi]         = bus.req_valid[gi];
                assign floatPad[gi]         = bus.req_float[gi];
                assign regPad[gi]           = bus.req_reg[gi*ADDR_W +: ADDR_W];
                assign dataPad[gi]          = bus.req_data[gi*DATA_W +: DATA_W];
                assign bus.req_ready[gi]    = rst_n && grantValid && (winner == 2'(gi));
            end else begin : g_unused
                assign validPad[gi] = 1'b0;
                assign floatPad[gi] = 1'b0;
                assign regPad[gi]   = '0;
                assign dataPad[gi]  = '0;
            end
        end
    endgenerate

    // Scan starts one past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        grantValid = 1'b0;
        winner     = 2'd0;
        scanIdx    = 3'd0;
        if (!bus.hold) begin
            for (int off = 1; off <= NREQ; off++) begin
                scanIdx = {1'b0, rrPtr} + 3'(off);
                if (scanIdx >= 3'(NREQ)) begin
                    scanIdx = scanIdx - 3'(NREQ);
                end
                if (!grantValid && validPad[scanIdx[1:0]]) begin
                    grantValid = 1'b1;
                    winner     = scanIdx[1:0];
                end
            end
        end
    end

    // Integer r0 is hardwired: the beat is consumed but never reaches the regfile.
    assign discard = !floatPad[winner] && (regPad[winner] == '0);

    always_comb begin
        if (bus.hold) begin
            nextState = HOLD;
        end else if (grantValid && !discard) begin
            nextState = WRITE;
        end else begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rrPtr      <= 2'(NREQ - 1);
            wrReg      <= '0;
            wrData     <= '0;
            wrFloat    <= 1'b0;
            grantId    <= 2'd0;
            writesDone <= '0;
        end else begin
            state <= nextState;
            if (state == WRITE) begin
                writesDone <= writesDone + CNT_W'(1);
            end
            if (grantValid) begin
                wrReg   <= regPad[winner];
                wrData  <= dataPad[winner];
                wrFloat <= floatPad[winner];
                grantId <= winner;
                rrPtr   <= winner;
            end
        end
    end

    assign bus.wr_en       = (state == WRITE);
    assign bus.wr_reg      = wrReg;
    assign bus.wr_data     = wrData;
    assign bus.wr_float    = wrFloat;
    assign bus.grant_id    = grantId;
    assign bus.writes_done = writesDone;
endmodule
